// File: rtl/ising_run_ctrl.sv
// ----------------------------------------------------------------------------
// ising_run_ctrl
// Sequences one annealing run on a register-mapped Ising core. It programs
// the cutoff and max registers and sets the start register. It then waits
// run_cycles cycles and reads back the phase of N spins, one read at a time.
// Finally it clears the start register and pulses done.
//
// Ports
//   clk, axi_rst            : sole clock; asynchronous active-high reset
//   start, abort            : run request (taken only in IDLE) / early stop
//   cfg_cutoff, cfg_max,
//   cfg_run_cycles          : run configuration, captured when start is taken
//   wready, wr_addr, wdata  : one-cycle register write strobe with addr/data
//   arvalid_q, araddr_q,
//   rready                  : read request (one cycle) and read-accept
//   rvalid, rresp, rdata    : read response; rresp=1 flags a slave error
//   busy, done              : not-idle indicator / one-cycle completion pulse
//   phase_out               : spin phases (rdata[0] of each read)
//   err_timeout, err_resp   : sticky error flags for the last run
// ----------------------------------------------------------------------------
module ising_run_ctrl #(
    parameter int          N               = 3,
    parameter int          RD_TIMEOUT      = 16,
    parameter logic [31:0] CTR_CUTOFF_ADDR = 32'h0000_0000,
    parameter logic [31:0] CTR_MAX_ADDR    = 32'h0000_0004,
    parameter logic [31:0] START_ADDR      = 32'h0000_0008,
    parameter logic [31:0] PHASE_ADDR_BASE = 32'h0000_0100
) (
    input  logic         clk,
    input  logic         axi_rst,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  cfg_cutoff,
    input  logic [31:0]  cfg_max,
    input  logic [31:0]  cfg_run_cycles,
    output logic         wready,
    output logic [31:0]  wr_addr,
    output logic [31:0]  wdata,
    output logic         arvalid_q,
    output logic [31:0]  araddr_q,
    output logic         rready,
    input  logic         rvalid,
    input  logic         rresp,
    input  logic [31:0]  rdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] phase_out,
    output logic         err_timeout,
    output logic         err_resp
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(RD_TIMEOUT - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_CUTOFF = 4'd1;
    localparam logic [3:0] S_WR_MAX    = 4'd2;
    localparam logic [3:0] S_WR_START  = 4'd3;
    localparam logic [3:0] S_RUN       = 4'd4;
    localparam logic [3:0] S_RD_REQ    = 4'd5;
    localparam logic [3:0] S_RD_WAIT   = 4'd6;
    localparam logic [3:0] S_WR_STOP   = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    logic [3:0]    r_state;
    logic [31:0]   r_cutoff;
    logic [31:0]   r_max;
    logic [31:0]   r_run_cycles;
    logic [31:0]   r_cnt;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_wait;
    logic [N-1:0]  r_phase;
    logic          r_err_timeout;
    logic          r_err_resp;

    logic [N-1:0]  w_bit_sel;
    logic [31:0]   w_araddr;
    logic          w_last;
    logic          w_unused;

    // One-hot select of the spin currently being read.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel
            assign w_bit_sel[gi] = (r_idx == IW'(gi));
        end
    endgenerate

    assign w_araddr = PHASE_ADDR_BASE + {{(30 - IW){1'b0}}, r_idx, 2'b00};
    assign w_last   = (r_idx == LAST_IDX);
    assign w_unused = ^rdata[31:1];

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state       <= S_IDLE;
            r_cutoff      <= '0;
            r_max         <= '0;
            r_run_cycles  <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_wait        <= '0;
            r_phase       <= '0;
            r_err_timeout <= 1'b0;
            r_err_resp    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cutoff      <= cfg_cutoff;
                        r_max         <= cfg_max;
                        r_run_cycles  <= cfg_run_cycles;
                        r_phase       <= '0;
                        r_err_timeout <= 1'b0;
                        r_err_resp    <= 1'b0;
                        r_state       <= S_WR_CUTOFF;
                    end
                end
                S_WR_CUTOFF: r_state <= abort ? S_WR_STOP : S_WR_MAX;
                S_WR_MAX:    r_state <= abort ? S_WR_STOP : S_WR_START;
                S_WR_START: begin
                    r_idx <= '0;
                    if (abort) begin
                        r_state <= S_WR_STOP;
                    end else if (r_run_cycles == 32'd0) begin
                        r_state <= S_RD_REQ;
                    end else begin
                        r_cnt   <= r_run_cycles;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // r_cnt holds the cycles left including this one.
                    r_cnt <= r_cnt - 32'd1;
                    if (abort) begin
                        r_state <= S_WR_STOP;
                    end else if (r_cnt == 32'd1) begin
                        r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    r_wait  <= '0;
                    r_state <= abort ? S_WR_STOP : S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Abort wins over a response arriving in the same cycle.
                    if (abort) begin
                        r_state <= S_WR_STOP;
                    end else if (rvalid || (r_wait == WAIT_MAX)) begin
                        if (rvalid) begin
                            r_phase <= (r_phase & ~w_bit_sel) | (w_bit_sel & {N{rdata[0]}});
                            if (rresp) begin
                                r_err_resp <= 1'b1;
                            end
                        end else begin
                            // Timed out: the phase bit keeps its cleared value.
                            r_err_timeout <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_WR_STOP;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_RD_REQ;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WR_STOP: r_state <= S_DONE;
                S_DONE:    r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Write channel is a pure decode of the state so it reads 0 during reset.
    always_comb begin
        wready  = 1'b0;
        wr_addr = '0;
        wdata   = '0;
        case (r_state)
            S_WR_CUTOFF: begin
                wready  = 1'b1;
                wr_addr = CTR_CUTOFF_ADDR;
                wdata   = r_cutoff;
            end
            S_WR_MAX: begin
                wready  = 1'b1;
                wr_addr = CTR_MAX_ADDR;
                wdata   = r_max;
            end
            S_WR_START: begin
                wready  = 1'b1;
                wr_addr = START_ADDR;
                wdata   = 32'd1;
            end
            S_WR_STOP: begin
                wready  = 1'b1;
                wr_addr = START_ADDR;
                wdata   = 32'd0;
            end
            default: ;
        endcase
    end

    assign arvalid_q   = (r_state == S_RD_REQ);
    assign araddr_q    = ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT)) ? w_araddr : '0;
    assign rready      = (r_state == S_RD_WAIT);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign phase_out   = r_phase;
    assign err_timeout = r_err_timeout;
    assign err_resp    = r_err_resp;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ising_run_ctrl
// Scoreboarded bench: each scenario queues the write/read/done events the
// controller should produce (with their cycle number counted from the start
// edge). run_and_score pops and compares them as the DUT produces them. A
// small responder answers read requests one cycle after arvalid_q.
// ----------------------------------------------------------------------------
module tb_ising_run_ctrl;

    localparam int          NB       = 3;
    localparam int          TMO      = 16;
    localparam logic [31:0] A_CUTOFF = 32'h0000_0000;
    localparam logic [31:0] A_MAX    = 32'h0000_0004;
    localparam logic [31:0] A_START  = 32'h0000_0008;
    localparam logic [31:0] A_PHASE  = 32'h0000_0100;

    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic          clk = 1'b0;
    logic          axi_rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   cfg_cutoff = '0;
    logic [31:0]   cfg_max = '0;
    logic [31:0]   cfg_run_cycles = '0;
    logic          wready;
    logic [31:0]   wr_addr;
    logic [31:0]   wdata;
    logic          arvalid_q;
    logic [31:0]   araddr_q;
    logic          rready;
    logic          rvalid = 1'b0;
    logic          rresp = 1'b0;
    logic [31:0]   rdata = '0;
    logic          busy;
    logic          done;
    logic [NB-1:0] phase_out;
    logic          err_timeout;
    logic          err_resp;

    int tests  = 0;
    int failed = 0;

    ev_t exp_q[$];
    int  abort_at   = 0;
    int  restart_at = 0;

    // Responder configuration
    logic [NB-1:0] resp_bits   = '0;
    logic [NB-1:0] resp_silent = '0;
    logic [NB-1:0] resp_err    = '0;
    bit            pend = 0;
    int            pidx = 0;

    ising_run_ctrl #(
        .N(NB),
        .RD_TIMEOUT(TMO),
        .CTR_CUTOFF_ADDR(A_CUTOFF),
        .CTR_MAX_ADDR(A_MAX),
        .START_ADDR(A_START),
        .PHASE_ADDR_BASE(A_PHASE)
    ) dut (
        .clk(clk),
        .axi_rst(axi_rst),
        .start(start),
        .abort(abort),
        .cfg_cutoff(cfg_cutoff),
        .cfg_max(cfg_max),
        .cfg_run_cycles(cfg_run_cycles),
        .wready(wready),
        .wr_addr(wr_addr),
        .wdata(wdata),
        .arvalid_q(arvalid_q),
        .araddr_q(araddr_q),
        .rready(rready),
        .rvalid(rvalid),
        .rresp(rresp),
        .rdata(rdata),
        .busy(busy),
        .done(done),
        .phase_out(phase_out),
        .err_timeout(err_timeout),
        .err_resp(err_resp)
    );

    always #5 clk = ~clk;

    // Responder: latch a request seen in the RD_REQ cycle, answer during the
    // following cycle unless that bit is configured silent.
    always @(negedge clk) begin
        if (arvalid_q === 1'b1) begin
            pend = 1;
            pidx = int'((araddr_q - A_PHASE) >> 2);
        end
    end

    always @(posedge clk) begin
        #1;
        rvalid = 1'b0;
        rresp  = 1'b0;
        rdata  = '0;
        if (pend && !axi_rst) begin
            pend = 0;
            if (pidx >= 0 && pidx < NB && !resp_silent[pidx]) begin
                rvalid = 1'b1;
                rdata  = {31'd0, resp_bits[pidx]};
                rresp  = resp_err[pidx];
            end
        end
    end

    always @(posedge axi_rst) begin
        pend   = 0;
        rvalid = 1'b0;
    end

    function automatic void push_ev(int k, int c, logic [31:0] a, logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endfunction

    // Reference model of a complete (non-aborted) run.
    task automatic model_run(input logic [31:0] cut, input logic [31:0] mx, input int rc,
                             input int w0, input int w1, input int w2,
                             input logic [NB-1:0] ph, input logic eto, input logic ers);
        int t;
        int w[NB];
        w[0] = w0; w[1] = w1; w[2] = w2;
        push_ev(K_WR, 1, A_CUTOFF, cut);
        push_ev(K_WR, 2, A_MAX, mx);
        push_ev(K_WR, 3, A_START, 32'd1);
        t = 4 + rc;
        for (int b = 0; b < NB; b++) begin
            push_ev(K_RD, t, A_PHASE + 32'(4 * b), 32'd0);
            t += 1 + w[b];
        end
        push_ev(K_WR, t, A_START, 32'd0);
        push_ev(K_DONE, t + 1, 32'd0, {27'd0, ers, eto, ph});
    endtask

    // Caller must be at a negedge with the DUT in IDLE.
    task automatic start_run(input logic [31:0] cut, input logic [31:0] mx, input logic [31:0] rc);
        cfg_cutoff     = cut;
        cfg_max        = mx;
        cfg_run_cycles = rc;
        start          = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_and_score(input string name, input int budget);
        int   n;
        int   k;
        bit   seen_done;
        ev_t  e;
        logic [31:0] a;
        logic [31:0] d;
        n = 0;
        seen_done = 0;
        while (!seen_done && n < budget) begin
            @(negedge clk);
            n++;
            abort = (n == abort_at);
            if (n == restart_at) begin
                start          = 1'b1;
                cfg_cutoff     = 32'hDEAD_0001;
                cfg_max        = 32'hDEAD_0002;
                cfg_run_cycles = 32'd7;
            end else begin
                start = 1'b0;
            end
            k = -1;
            a = '0;
            d = '0;
            if (wready) begin
                k = K_WR; a = wr_addr; d = wdata;
            end else if (arvalid_q) begin
                k = K_RD; a = araddr_q;
            end else if (done) begin
                k = K_DONE; d = {27'd0, err_resp, err_timeout, phase_out}; seen_done = 1;
            end
            if (k >= 0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("[TB] FAIL %s unexpected event kind=%0d cyc=%0d addr=%h data=%h", name, k, n, a, d);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== k || e.cyc !== n || e.a !== a || e.d !== d)  begin
                        failed++;
                        $display("[TB] FAIL %s event got kind=%0d cyc=%0d addr=%h data=%h, expected kind=%0d cyc=%0d addr=%h data=%h",
                                 name, k, n, a, d, e.kind, e.cyc, e.a, e.d);
                    end else begin
                        $display("[TB] %s kind=%0d cyc=%0d addr=%h data=%h ok", name, k, n, a, d);
                    end
                end
            end
        end
        abort = 1'b0;
        start = 1'b0;
        abort_at = 0;
        restart_at = 0;
        tests++;
        if (!seen_done) begin
            failed++;
            $display("[TB] FAIL %s no done within %0d cycles, got busy=%b expected done=1", name, budget, busy);
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("[TB] FAIL %s %0d expected events never seen, expected 0 left", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++;
        if ({wready, arvalid_q, rready, busy, done, err_timeout, err_resp} !== 7'd0) begin
            failed++;
            $display("[TB] FAIL reset_ctrl got %b expected 0000000",
                     {wready, arvalid_q, rready, busy, done, err_timeout, err_resp});
        end
        tests++;
        if ({wr_addr, wdata, araddr_q} !== 96'd0 || phase_out !== '0) begin
            failed++;
            $display("[TB] FAIL reset_data got wr_addr=%h wdata=%h araddr=%h phase=%b expected all 0",
                     wr_addr, wdata, araddr_q, phase_out);
        end
        $display("[TB] reset outputs checked");
        axi_rst = 1'b0;   // released at a negedge; the next rising edge must take start
    endtask

    task automatic test_nominal;
        resp_bits = 3'b101; resp_silent = '0; resp_err = '0;
        model_run(32'd5, 32'd100, 10, 1, 1, 1, 3'b101, 1'b0, 1'b0);
        start_run(32'd5, 32'd100, 32'd10);
        run_and_score("nominal", 100);
        repeat (3) @(negedge clk);
        tests++;
        if (phase_out !== 3'b101 || busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("[TB] FAIL nominal_hold got phase=%b busy=%b done=%b expected 101 0 0", phase_out, busy, done);
        end
    endtask

    task automatic test_zero_run;
        @(negedge clk);
        resp_bits = 3'b011; resp_silent = '0; resp_err = '0;
        model_run(32'd9, 32'd33, 0, 1, 1, 1, 3'b011, 1'b0, 1'b0);
        start_run(32'd9, 32'd33, 32'd0);
        run_and_score("zero_run", 100);
    endtask

    task automatic test_timeout;
        @(negedge clk);
        resp_bits = 3'b111; resp_silent = 3'b010; resp_err = '0;
        model_run(32'd1, 32'd2, 3, 1, TMO, 1, 3'b101, 1'b1, 1'b0);
        start_run(32'd1, 32'd2, 32'd3);
        run_and_score("timeout", 100);
        resp_silent = '0;
    endtask

    task automatic test_resp_err;
        @(negedge clk);
        resp_bits = 3'b100; resp_silent = '0; resp_err = 3'b100;
        model_run(32'h1234_5678, 32'hFFFF_FFFF, 2, 1, 1, 1, 3'b100, 1'b0, 1'b1);
        start_run(32'h1234_5678, 32'hFFFF_FFFF, 32'd2);
        run_and_score("resp_err", 100);
        resp_err = '0;
    endtask

    task automatic test_abort_run;
        @(negedge clk);
        resp_bits = 3'b111;
        push_ev(K_WR, 1, A_CUTOFF, 32'd5);
        push_ev(K_WR, 2, A_MAX, 32'd100);
        push_ev(K_WR, 3, A_START, 32'd1);
        push_ev(K_WR, 7, A_START, 32'd0);
        push_ev(K_DONE, 8, 32'd0, 32'd0);
        abort_at = 6;
        start_run(32'd5, 32'd100, 32'd10);
        run_and_score("abort_run", 100);
    endtask

    task automatic test_abort_vs_read;
        @(negedge clk);
        resp_bits = 3'b111;
        push_ev(K_WR, 1, A_CUTOFF, 32'd4);
        push_ev(K_WR, 2, A_MAX, 32'd8);
        push_ev(K_WR, 3, A_START, 32'd1);
        push_ev(K_RD, 4, A_PHASE, 32'd0);
        push_ev(K_RD, 6, A_PHASE + 32'd4, 32'd0);
        push_ev(K_WR, 8, A_START, 32'd0);
        push_ev(K_DONE, 9, 32'd0, 32'd1);
        abort_at = 7;   // same cycle as the bit-1 response
        start_run(32'd4, 32'd8, 32'd0);
        run_and_score("abort_vs_read", 100);
    endtask

    task automatic test_reset_midrun;
        int n;
        @(negedge clk);
        resp_bits = 3'b111;
        start_run(32'd5, 32'd100, 32'd2);
        n = 0;
        while (rready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (rready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL midrun_reach got rready=%b expected 1", rready);
        end
        #2 axi_rst = 1'b1;
        #1;
        tests++;
        if ({wready, arvalid_q, rready, busy, done, err_timeout, err_resp} !== 7'd0 ||
            {wr_addr, wdata, araddr_q} !== 96'd0 || phase_out !== '0) begin
            failed++;
            $display("[TB] FAIL midrun_async got ctrl=%b araddr=%h phase=%b expected all 0",
                     {wready, arvalid_q, rready, busy, done, err_timeout, err_resp}, araddr_q, phase_out);
        end
        repeat (2) @(negedge clk);
        axi_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (wready !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("[TB] FAIL midrun_no_stop got wready=%b busy=%b expected 0 0", wready, busy);
            end
        end
        $display("[TB] reset during RD_WAIT checked");
    endtask

    task automatic test_back_to_back;
        resp_bits = 3'b110;
        model_run(32'd77, 32'd88, 4, 1, 1, 1, 3'b110, 1'b0, 1'b0);
        restart_at = 1;   // new start with different cfg while busy
        start_run(32'd77, 32'd88, 32'd4);
        run_and_score("busy_start", 100);
        @(negedge clk);
        resp_bits = 3'b001;
        model_run(32'd3, 32'd6, 1, 1, 1, 1, 3'b001, 1'b0, 1'b0);
        start_run(32'd3, 32'd6, 32'd1);
        run_and_score("back_to_back", 100);
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_zero_run;
        test_timeout;
        test_resp_err;
        test_abort_run;
        test_abort_vs_read;
        test_reset_midrun;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ising_run_ctrl.md
ISING_RUN_CTRL -- requirements
Module: ising_run_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, number of spins whose phase is read back.
REQ-002 SHALL have parameter RD_TIMEOUT, default 16, max cycles to wait for rvalid per read.
REQ-003 SHALL have port clk, input, 1, sole clock; one clock; all logic on rising edge.
REQ-004 SHALL have port axi_rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, run-request pulse; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, terminates the run early.
REQ-007 SHALL have ports cfg_cutoff, cfg_max, cfg_run_cycles, input, 32 each; captured on accepted start.
REQ-008 SHALL have ports wready, output, 1 (write strobe); wr_addr, output, 32; wdata, output, 32.
REQ-009 SHALL have ports arvalid_q, output, 1; araddr_q, output, 32; rready, output, 1.
REQ-010 SHALL have ports rvalid, input, 1; rresp, input, 1; rdata, input, 32.
REQ-011 SHALL have ports busy, output, 1; done, output, 1; phase_out, output, N; err_timeout, output, 1; err_resp, output, 1.

Function
REQ-012 SHALL implement FSM IDLE -> WR_CUTOFF -> WR_MAX -> WR_START -> RUN -> RD_REQ <-> RD_WAIT -> WR_STOP -> DONE -> IDLE.
REQ-013 SHALL, in IDLE with start=1, capture cfg_* inputs, clear phase_out/err_timeout/err_resp, and enter WR_CUTOFF next cycle.
REQ-014 SHALL spend exactly one cycle in each WR_* state with wready=1: WR_CUTOFF {CTR_CUTOFF_ADDR, cutoff}, WR_MAX {CTR_MAX_ADDR, max}, WR_START {START_ADDR, 1}, WR_STOP {START_ADDR, 0}; wready=0 elsewhere.
REQ-015 SHALL remain in RUN exactly run_cycles cycles (32-bit down-counter); run_cycles=0 skips RUN (WR_START -> RD_REQ).
REQ-016 SHALL maintain bit index i (clog2(N) bits, min 1), reset to 0 on entry to RUN.
REQ-017 SHALL drive arvalid_q=1 for exactly one cycle in RD_REQ with araddr_q = PHASE_ADDR_BASE + 4*i; arvalid_q=0 in all other states.
REQ-018 SHALL hold araddr_q stable from RD_REQ through end of RD_WAIT; 0 otherwise.
REQ-019 SHALL drive rready=1 throughout RD_WAIT, 0 elsewhere.
REQ-020 SHALL complete a read when rvalid&rready: phase_out[i] <= rdata[0]; err_resp set if rresp=1.
REQ-021 SHALL, after a completed read, go to RD_REQ with i+1 if i<N-1, else WR_STOP.
REQ-022 SHALL count RD_WAIT cycles; if rvalid not seen within RD_TIMEOUT cycles, set err_timeout, leave phase_out[i]=0, and advance as in REQ-021.
REQ-023 SHALL ignore rvalid outside RD_WAIT.
REQ-024 SHALL, on abort=1 in any state other than IDLE, WR_STOP, DONE, go to WR_STOP next cycle; phase bits not yet read stay 0.
REQ-025 SHALL give abort priority over read completion in the same cycle.
REQ-026 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-027 SHALL drive busy=1 in every state except IDLE; start ignored while busy.
REQ-028 SHALL hold phase_out, err_timeout, err_resp (sticky) from DONE until next accepted start.
REQ-029 SHALL issue at most one outstanding read; latency start->done = 5 + run_cycles + sum over bits of (1 + read wait).

Reset
REQ-030 SHALL, on axi_rst=1, asynchronously force IDLE and all outputs to 0 (wready, wr_addr, wdata, arvalid_q, araddr_q, rready, busy, done, phase_out, err_*), counters/index to 0.
REQ-031 SHALL, on reset mid-run, not issue WR_STOP; the responder's own reset clears its start register.
REQ-032 SHALL accept start on the first rising edge after axi_rst deasserts.

Verification
REQ-033 Nominal: N=3, cutoff=5, max=100, run_cycles=10, responder rvalid 1 cycle after arvalid, phase bits 1,0,1 -> writes 5,100,1 in order, reads 0x..00/04/08 offsets, phase_out=3'b101, done pulse at cycle 5+10+3*2+... exact, err_*=0.
REQ-034 run_cycles=0 -> first arvalid_q one cycle after WR_START strobe.
REQ-035 Responder never answers bit 1 -> err_timeout=1 after RD_TIMEOUT=16 cycles, phase_out[1]=0, other bits correct, WR_STOP still issued.
REQ-036 rresp=1 on bit 2 with rdata[0]=1 -> err_resp=1, phase_out[2]=1.
REQ-037 abort during RUN -> next cycle wready=1, wr_addr=START_ADDR, wdata=0, then done, phase_out=0.
REQ-038 axi_rst asserted during RD_WAIT -> all outputs 0 immediately (async), no WR_STOP; start after release runs normally; start while busy has no effect.
